cdb_writeback: RTL and testbench

- Producer side of the FP register-file write port.
- Collects completed results from the functional units (adder, multiplier, load buffer) and arbitrates one per cycle onto the Common Data Bus (CDB).
- Keeps the register status table (the pending producer tag per FP register) and drives the register-file write.
- The register file is written only when the broadcast tag still owns the destination register.

---
 rtl/cdb_writeback.sv | 109 ++++++++++
 tb/tb_cdb_writeback.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_writeback.sv
// cdb_writeback: arbitrates functional-unit results onto the CDB, tracks register status and writes the FP register file; CDB_RR_ARB_EN selects round-robin over fixed priority
module cdb_writeback #(
  parameter int N_SRC  = 3,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_SRC-1:0]          srcValid,
  output logic [N_SRC-1:0]          srcReady,
  input  logic [N_SRC*TAG_W-1:0]    srcTag,
  input  logic [N_SRC*DATA_W-1:0]   srcData,
  input  logic                      issueValid,
  input  logic [2:0]                issueDest,
  input  logic [TAG_W-1:0]          issueTag,
  input  logic [2:0]                rdAddr,
  output logic [TAG_W-1:0]          rdTag,
  output logic                      cdbValid,
  output logic [TAG_W-1:0]          cdbTag,
  output logic [DATA_W-1:0]         cdbData,
  output logic                      wrEnable,
  output logic [2:0]                wrAddress,
  output logic [DATA_W-1:0]         wrData
);
  localparam int PW = N_SRC > 1 ? $clog2(N_SRC) : 1;
  logic [TAG_W-1:0] status [8];
  logic [N_SRC-1:0] grant;
  logic [PW-1:0]    gidx;
  logic [7:0]       match;
  logic [2:0]       wr_sel;
`ifdef CDB_RR_ARB_EN
  logic [PW-1:0]    ptr;
  // round-robin pick: scan from the pointer, the first requester found wins
  always_comb begin
    grant = '0;
    gidx = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (srcValid[(int'(ptr) + k) % N_SRC]) begin
        grant = '0;
        grant[(int'(ptr) + k) % N_SRC] = 1'b1;
        gidx = PW'((int'(ptr) + k) % N_SRC);
      end
    end
    if (reset) grant = '0;
  end
  // pointer advances past the granted source, holds when idle
  always_ff @(posedge clock)
    if (reset) ptr <= '0;
    else if (|grant) ptr <= PW'((int'(gidx) + 1) % N_SRC);
`else
  // fixed priority pick: lowest-numbered requester wins
  always_comb begin
    grant = '0;
    gidx = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (srcValid[k]) begin
        grant = '0;
        grant[k] = 1'b1;
        gidx = PW'(k);
      end
    end
    if (reset) grant = '0;
  end
`endif
  assign srcReady = grant;
  assign rdTag = rdAddr == 3'd0 ? '0 : status[rdAddr];
  // registers still owned by the broadcast tag; a zero entry never matches
  always_comb begin
    match = '0;
    wr_sel = '0;
    for (int r = 7; r >= 1; r--) begin
      match[r] = cdbValid && status[r] != '0 && status[r] == cdbTag;
      if (match[r]) wr_sel = 3'(r);
    end
  end
  // broadcast the granted result one cycle after the grant
  always_ff @(posedge clock)
    if (reset) begin
      cdbValid <= 1'b0;
      cdbTag <= '0;
      cdbData <= '0;
    end else begin
      cdbValid <= |grant;
      if (|grant) begin
        cdbTag <= srcTag[int'(gidx)*TAG_W +: TAG_W];
        cdbData <= srcData[int'(gidx)*DATA_W +: DATA_W];
      end
    end
  // register-file write for the lowest owning register
  always_ff @(posedge clock)
    if (reset) begin
      wrEnable <= 1'b0;
      wrAddress <= '0;
      wrData <= '0;
    end else begin
      wrEnable <= |match;
      wrAddress <= wr_sel;
      wrData <= cdbData;
    end
  // status table: a new issue overrides a same-cycle clear
  always_ff @(posedge clock)
    if (reset) begin
      for (int r = 0; r < 8; r++) status[r] <= '0;
    end else begin
      for (int r = 1; r < 8; r++)
        if (issueValid && issueDest == 3'(r)) status[r] <= issueTag;
        else if (match[r]) status[r] <= '0;
    end
endmodule

// File: tb/tb_cdb_writeback.sv
// tb_cdb_writeback: scoreboard bench for cdb_writeback
module tb_cdb_writeback;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  srcValid = '0;
  logic [2:0]  srcReady;
  logic [8:0]  srcTag = '0;
  logic [47:0] srcData = '0;
  logic        issueValid = 1'b0;
  logic [2:0]  issueDest = '0;
  logic [2:0]  issueTag = '0;
  logic [2:0]  rdAddr = '0;
  logic [2:0]  rdTag;
  logic        cdbValid;
  logic [2:0]  cdbTag;
  logic [15:0] cdbData;
  logic        wrEnable;
  logic [2:0]  wrAddress;
  logic [15:0] wrData;

  typedef struct {int cyc; logic [2:0] tag; logic [15:0] data;} cdb_t;
  typedef struct {int cyc; logic [2:0] addr; logic [15:0] data;} wr_t;
  cdb_t cdb_q[$];
  wr_t  wr_q[$];
  cdb_t ce;
  wr_t  we;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [2:0] exp_stat [8];

  cdb_writeback dut (
    .clock(clock), .reset(reset), .srcValid(srcValid), .srcReady(srcReady),
    .srcTag(srcTag), .srcData(srcData), .issueValid(issueValid),
    .issueDest(issueDest), .issueTag(issueTag), .rdAddr(rdAddr), .rdTag(rdTag),
    .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbData(cdbData),
    .wrEnable(wrEnable), .wrAddress(wrAddress), .wrData(wrData)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if (cdb_q.size() != 0 && cdb_q[0].cyc == cyc) begin
        ce = cdb_q.pop_front();
        if ({cdbValid, cdbTag, cdbData} !== {1'b1, ce.tag, ce.data}) begin
          errors++;
          $display("FAIL cdb cyc=%0d got v=%b tag=%0d data=%h expected v=1 tag=%0d data=%h",
                   cyc, cdbValid, cdbTag, cdbData, ce.tag, ce.data);
        end
      end else if (cdbValid !== 1'b0) begin
        errors++;
        $display("FAIL cdb_idle cyc=%0d got v=%b expected v=0", cyc, cdbValid);
      end
      checks++;
      if (wr_q.size() != 0 && wr_q[0].cyc == cyc) begin
        we = wr_q.pop_front();
        if ({wrEnable, wrAddress, wrData} !== {1'b1, we.addr, we.data}) begin
          errors++;
          $display("FAIL wr cyc=%0d got en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h",
                   cyc, wrEnable, wrAddress, wrData, we.addr, we.data);
        end
      end else if (wrEnable !== 1'b0) begin
        errors++;
        $display("FAIL wr_idle cyc=%0d got en=%b addr=%0d expected en=0", cyc, wrEnable, wrAddress);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic idle();
    srcValid = '0;
    issueValid = 1'b0;
    issueDest = '0;
    issueTag = '0;
  endtask

  task automatic issue(input logic [2:0] d, input logic [2:0] t);
    @(negedge clock);
    idle();
    issueValid = 1'b1;
    issueDest = d;
    issueTag = t;
    if (d != 0) exp_stat[d] = t;
  endtask

  task automatic send(input int s, input logic [2:0] t, input logic [15:0] d, input logic [2:0] wa, input bit wexp);
    @(negedge clock);
    idle();
    srcValid[s] = 1'b1;
    srcTag[s*3 +: 3] = t;
    srcData[s*16 +: 16] = d;
    #1;
    checks++;
    if (srcReady !== 3'(1 << s)) begin
      errors++;
      $display("FAIL send_ready got %b expected %b", srcReady, 3'(1 << s));
    end
    cdb_q.push_back('{cyc + 1, t, d});
    if (wexp) begin
      wr_q.push_back('{cyc + 2, wa, d});
      for (int r = 1; r < 8; r++) if (exp_stat[r] == t) exp_stat[r] = 3'd0;
    end
  endtask

  task automatic check_status(input string name);
    for (int r = 0; r < 8; r++) begin
      rdAddr = 3'(r);
      #1;
      checks++;
      if (rdTag !== exp_stat[r]) begin
        errors++;
        $display("FAIL %s rdTag[%0d] got %0d expected %0d", name, r, rdTag, exp_stat[r]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    srcValid = 3'b111;
    @(posedge clock);
    @(negedge clock);
    #1;
    checks++;
    if (srcReady !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready got %b expected 000", srcReady);
    end
    mon_en = 1'b1;
    idle();
    reset = 1'b0;
    for (int r = 0; r < 8; r++) exp_stat[r] = 3'd0;
    check_status("reset_status");
  endtask

  task automatic test_contention();
    int g;
    @(negedge clock);
    idle();
    srcValid = 3'b111;
    srcTag = {3'd3, 3'd2, 3'd1};
    srcData = {16'h1002, 16'h1001, 16'h1000};
    for (int k = 0; k < 6; k++) begin
      if (k != 0) @(negedge clock);
`ifdef CDB_RR_ARB_EN
      g = k % 3;
`else
      g = 0;
`endif
      #1;
      checks++;
      if (srcReady !== 3'(1 << g)) begin
        errors++;
        $display("FAIL contention_grant step=%0d got %b expected %b", k, srcReady, 3'(1 << g));
      end
      cdb_q.push_back('{cyc + 1, 3'(g + 1), 16'h1000 + 16'(g)});
    end
    @(negedge clock);
    idle();
  endtask

  task automatic test_basic();
    issue(3'd3, 3'd5);
    send(1, 3'd5, 16'h1234, 3'd3, 1'b1);
    @(negedge clock);
    idle();
    @(negedge clock);
    check_status("basic_status");
  endtask

  task automatic test_stale();
    issue(3'd2, 3'd4);
    issue(3'd2, 3'd6);
    send(0, 3'd4, 16'hAAAA, 3'd0, 1'b0);
    @(negedge clock);
    idle();
    @(negedge clock);
    check_status("stale_status");
  endtask

  task automatic test_conflict();
    issue(3'd3, 3'd5);
    send(1, 3'd5, 16'h5555, 3'd3, 1'b1);
    issue(3'd3, 3'd7);
    @(negedge clock);
    idle();
    check_status("conflict_status");
  endtask

  task automatic test_multi_match();
    issue(3'd6, 3'd1);
    issue(3'd5, 3'd1);
    send(2, 3'd1, 16'hC0DE, 3'd5, 1'b1);
    @(negedge clock);
    idle();
    @(negedge clock);
    check_status("multi_status");
  endtask

  task automatic test_issue_zero();
    issue(3'd0, 3'd3);
    @(negedge clock);
    idle();
    check_status("zero_dest_status");
    send(2, 3'd0, 16'hBEEF, 3'd0, 1'b0);
    @(negedge clock);
    idle();
    @(negedge clock);
    check_status("zero_tag_status");
  endtask

  task automatic test_reset_mid();
    issue(3'd1, 3'd2);
    send(0, 3'd2, 16'h2222, 3'd0, 1'b0);
    @(negedge clock);
    srcValid = 3'b111;
    reset = 1'b1;
    #1;
    checks++;
    if (srcReady !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_ready got %b expected 000", srcReady);
    end
    @(negedge clock);
    idle();
    reset = 1'b0;
    for (int r = 0; r < 8; r++) exp_stat[r] = 3'd0;
    check_status("reset_mid_status");
  endtask

  initial begin
    idle();
    test_reset();
    test_contention();
    test_basic();
    test_stale();
    test_conflict();
    test_multi_match();
    test_issue_zero();
    test_reset_mid();
    repeat (3) @(negedge clock);
    checks++;
    if (cdb_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending cdb=%0d wr=%0d expected 0", cdb_q.size(), wr_q.size());
    end
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
